melody_player: RTL and testbench

//  Sequencer stage directly downstream of the 7-entry melody ROM. Drives the ROM address,

---
 rtl/melody_pkg.sv | 30 +++
 rtl/melody_player_tone_gen.sv | 60 ++++++
 rtl/melody_player.sv | 114 +++++++++++
 tb/tb_melody_player.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared types and defaults for the melody sequencer: FSM states, note codes,
// and the timing constants used for a 25 MHz system clock.
package melody_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [1:0] REST = 2'd0;
  localparam logic [1:0] N1   = 2'd1;
  localparam logic [1:0] N2   = 2'd2;
  localparam logic [1:0] N3   = 2'd3;

  localparam int unsigned NOTE_TICKS_DEF = 6_250_000;
  localparam int unsigned HALF_1_DEF     = 28_409;
  localparam int unsigned HALF_2_DEF     = 25_310;
  localparam int unsigned HALF_3_DEF     = 22_549;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/melody_player_tone_gen.sv
// Square-wave generator: toggles tone_out every HALF_c cycles for note code c,
// silent for a rest or while clear is held.
module tone_gen
  import melody_pkg::*;
#(
  parameter int unsigned HALF_1 = HALF_1_DEF,
  parameter int unsigned HALF_2 = HALF_2_DEF,
  parameter int unsigned HALF_3 = HALF_3_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [1:0] note_code,
  output logic       tone_out
);

  localparam int unsigned HALF_MAX = max3(HALF_1, HALF_2, HALF_3);
  localparam int unsigned HALF_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic [HALF_W-1:0] half_last;
  logic              tone_q, tone_d;

  always_comb begin
    half_last = '0;
    case (note_code)
      N1:      half_last = HALF_W'(HALF_1 - 1);
      N2:      half_last = HALF_W'(HALF_2 - 1);
      N3:      half_last = HALF_W'(HALF_3 - 1);
      default: half_last = '0;
    endcase
  end

  always_comb begin
    half_cnt_d = half_cnt_q;
    tone_d     = tone_q;
    if (clear || note_code == REST) begin
      half_cnt_d = '0;
      tone_d     = 1'b0;
    end else if (half_cnt_q == half_last) begin
      half_cnt_d = '0;
      tone_d     = ~tone_q;
    end else begin
      half_cnt_d = half_cnt_q + HALF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      tone_q     <= tone_d;
    end
  end

  assign tone_out = tone_q;

endmodule

// File: rtl/melody_player.sv
// Melody sequencer: walks the melody ROM address, holds each note for NOTE_TICKS
// cycles and drives the tone generator, with start/stop/busy/done control.
module melody_player
  import melody_pkg::*;
#(
  parameter int unsigned MELODY_LEN = 7,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned NOTE_TICKS = NOTE_TICKS_DEF,
  parameter int unsigned HALF_1     = HALF_1_DEF,
  parameter int unsigned HALF_2     = HALF_2_DEF,
  parameter int unsigned HALF_3     = HALF_3_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [1:0]        rom_q,
  output logic [1:0]        note_code,
  output logic              tone_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       DUR_W     = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [DUR_W-1:0]  DUR_LAST  = DUR_W'(NOTE_TICKS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MELODY_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [1:0]        note_q, note_d;
  logic              tone_clear;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dur_d   = dur_q;
    note_d  = note_q;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          addr_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = stop ? IDLE : LOAD;
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          note_d  = rom_q;
          dur_d   = '0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
        end else if (dur_q == DUR_LAST) begin
          if (addr_q != ADDR_LAST) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = FETCH;
          end else if (loop_en) begin
            addr_d  = '0;
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end else begin
          dur_d = dur_q + DUR_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dur_q   <= '0;
      note_q  <= REST;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dur_q   <= dur_d;
      note_q  <= note_d;
    end
  end

  // Clearing on the leaving edge too keeps the tone silent through the FETCH/LOAD gap.
  assign tone_clear = (state_q != PLAY) || (state_d != PLAY);

  tone_gen #(
    .HALF_1(HALF_1),
    .HALF_2(HALF_2),
    .HALF_3(HALF_3)
  ) u_tone_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tone_clear),
    .note_code(note_q),
    .tone_out (tone_out)
  );

  assign rom_addr  = addr_q;
  assign note_code = (state_q == PLAY) ? note_q : REST;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_melody_player.sv
// Randomised and directed bench for melody_player against a slot-position model
// of the melody timeline (each note is a NOTE_TICKS+2 cycle slot).
module tb_melody_player;

  localparam int T   = 16;
  localparam int LEN = 7;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, loop_en;
  logic [2:0] rom_addr;
  logic [1:0] rom_q, note_code;
  logic       tone_out, busy, done;

  logic [1:0] rom_mem [LEN];

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;

  // timeline model: active/done flags, note index, position inside the note slot
  bit m_active, m_done;
  int m_idx, m_pos;

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  melody_player #(
    .MELODY_LEN(LEN), .ADDR_W(3), .NOTE_TICKS(T),
    .HALF_1(4), .HALF_2(3), .HALF_3(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_q(rom_q), .note_code(note_code),
    .tone_out(tone_out), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int half_of(input int c);
    case (c)
      1: return 4;
      2: return 3;
      3: return 2;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_active = 0; m_done = 0; m_idx = 0; m_pos = 0;
  endtask

  task automatic model_edge(input logic s, input logic p);
    if (!rst_n) begin
      model_reset();
    end else if (!m_active) begin
      if (s && !p) begin
        m_active = 1; m_idx = 0; m_pos = 0;
        n_starts++;
        $display("txn %0d: start accepted loop_en=%0b t=%0t", n_starts, loop_en, $time);
      end
    end else if (m_done) begin
      m_done = 0; m_active = 0;
    end else if (p) begin
      m_active = 0;
    end else if (m_pos == T + 1) begin
      if (m_idx < LEN - 1) begin
        m_idx++; m_pos = 0;
      end else if (loop_en) begin
        m_idx = 0; m_pos = 0;
      end else begin
        m_done = 1;
      end
    end else begin
      m_pos++;
    end
  endtask

  task automatic check_outputs();
    bit play;
    int code, tone;
    play = m_active && !m_done && (m_pos >= 2);
    code = play ? int'(rom_mem[m_idx]) : 0;
    tone = (play && code != 0) ? (((m_pos - 2) / half_of(code)) % 2) : 0;
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    chk("rom_addr", rom_addr, m_idx);
    chk("note_code", note_code, code);
    chk("tone_out", tone_out, tone);
  endtask

  // called at a negedge: drive, take one edge, then check
  task automatic step(input logic s, input logic p);
    start = s;
    stop  = p;
    @(posedge clk);
    model_edge(s, p);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_until(input int idx, input int pos, input int maxc);
    int c = 0;
    while (!(m_active && !m_done && m_idx == idx && m_pos == pos) && c < maxc) begin
      step(0, 0);
      c++;
    end
    chk("reach_point", (c < maxc), 1);
  endtask

  initial begin
    int k;
    bit seen;
    rom_mem[0] = 2'd3; rom_mem[1] = 2'd2; rom_mem[2] = 2'd1; rom_mem[3] = 2'd2;
    rom_mem[4] = 2'd3; rom_mem[5] = 2'd3; rom_mem[6] = 2'd3;
    rst_n = 0; start = 0; stop = 0; loop_en = 0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(0, 0);
    rst_n = 1;
    for (int i = 0; i < 30; i++) step(0, 0);

    // full non-looping melody and done timing
    step(1, 0);
    k = 0;
    while (!done && k < 300) begin
      step(0, 0);
      k++;
    end
    chk("done_latency", k, LEN * (T + 2));
    for (int i = 0; i < 4; i++) step(0, 0);

    // start+stop together in IDLE
    step(1, 1);
    chk("start_stop_idle", busy, 0);
    for (int i = 0; i < 3; i++) step(0, 0);

    // stop on the 5th PLAY cycle of note 2
    step(1, 0);
    run_until(1, 6, 100);
    step(0, 1);
    chk("stop_busy", busy, 0);
    for (int i = 0; i < 10; i++) step(0, 0);

    // looping, then loop_en dropped during the last note
    loop_en = 1;
    step(1, 0);
    run_until(6, 5, 300);
    run_until(0, 5, 100);
    run_until(6, 5, 300);
    loop_en = 0;
    seen = 0;
    k = 0;
    while (!seen && k < 100) begin
      step(0, 0);
      seen = done;
      k++;
    end
    chk("loop_exit_done", seen, 1);
    for (int i = 0; i < 3; i++) step(0, 0);

    // asynchronous reset in the middle of note 4
    step(1, 0);
    run_until(3, 6, 200);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_addr", rom_addr, 0);
    chk("arst_note", note_code, 0);
    chk("arst_tone", tone_out, 0);
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) step(0, 0);
    rst_n = 1;
    step(1, 0);
    run_until(0, 8, 50);

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) loop_en = ~loop_en;
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 149) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
